// File: rtl/temp_log_pkg.sv
// Shared definitions for the temperature logger measurement scheduler.
// Holds the scheduler state encoding, frame constants, the status-byte bit
// positions and a small helper that identifies the byte-transmit states.
package temp_log_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_MEAS,
        TX_HDR,
        TX_SEQ,
        TX_DATA,
        TX_STAT,
        TX_CHK
    } state_t;

    localparam logic [7:0]  FRAME_HDR    = 8'hA5;
    localparam int unsigned FRAME_LEN    = 5;

    localparam int unsigned STAT_TIMEOUT = 0;
    localparam int unsigned STAT_OVERRUN = 1;
    localparam int unsigned STAT_ALARM   = 2;

    function automatic logic is_tx(input state_t s);
        return s inside {TX_HDR, TX_SEQ, TX_DATA, TX_STAT, TX_CHK};
    endfunction

endpackage

// File: rtl/temp_log_scheduler_tick_gen.sv
// sample_tick_gen: enable-gated period counter for the measurement scheduler.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   enable - 1 = count, 0 = counter held at 0
//   tick   - high for one cycle when the counter reaches PERIOD_CYCLES-1
// The counter wraps to 0 on the same edge that consumes the tick, so ticks
// repeat every PERIOD_CYCLES cycles while enable stays high.
module sample_tick_gen #(
    parameter int unsigned PERIOD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned    CW   = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(PERIOD_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // Gated so that a falling enable can never launch one last trigger.
    assign tick = enable && (count == LAST);

endmodule

// File: rtl/temp_log_scheduler.sv
// temp_log_scheduler: periodic measurement sequencer for the temperature logger.
// Pulses meas_start to the SPI reader each sample period, waits (with a
// timeout) for meas_valid, then streams a 5-byte frame
// {A5, seq, sample, status, xor-checksum} to the UART TX over valid/ready.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   enable                - periodic sampling enable
//   meas_start            - one-cycle measurement request (registered)
//   meas_data, meas_valid - SPI reader result and its strobe
//   tx_data, tx_valid     - frame byte to the UART TX, held until accepted
//   tx_ready              - UART TX accepts the byte this cycle
//   busy                  - high outside IDLE
//   frame_done            - one-cycle pulse after the checksum byte is taken
//   seq                   - sequence number of the next frame
// Optional build macro TEMP_LOG_ALARM_EN adds alarm_thresh (in) and alarm
// (out); status bit2 flags a sample above the threshold.
module temp_log_scheduler
    import temp_log_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES  = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic       meas_start,
    input  logic [7:0] meas_data,
    input  logic       meas_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
`ifdef TEMP_LOG_ALARM_EN
    input  logic [7:0] alarm_thresh,
    output logic       alarm,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] seq
);

    localparam int unsigned   TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_nxt;
    logic          tick;
    logic [TW-1:0] tcnt;
    logic [7:0]    sample;
    logic          timeout_q;
    logic          overrun;
    logic          alarm_bit;
    logic [7:0]    status_nxt;
    logic [7:0]    byte_nxt;
    logic          accept;
    logic          timeout_hit;
    logic          ovr_tick;

    sample_tick_gen #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .tick  (tick)
    );

    assign accept      = tx_valid && tx_ready;
    assign timeout_hit = (tcnt == TLAST);
    assign ovr_tick    = tick && (state != IDLE);
    assign busy        = (state != IDLE);

`ifdef TEMP_LOG_ALARM_EN
    logic alarm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_q <= 1'b0;
        end else if (state == WAIT_MEAS) begin
            if (meas_valid) begin
                alarm_q <= (meas_data > alarm_thresh);
            end else if (timeout_hit) begin
                alarm_q <= 1'b0;
            end
        end
    end

    assign alarm     = alarm_q;
    assign alarm_bit = alarm_q;
`else
    assign alarm_bit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (tick) state_nxt = TRIGGER;
            TRIGGER:   state_nxt = WAIT_MEAS;
            WAIT_MEAS: if (meas_valid || timeout_hit) state_nxt = TX_HDR;
            TX_HDR:    if (accept) state_nxt = TX_SEQ;
            TX_SEQ:    if (accept) state_nxt = TX_DATA;
            TX_DATA:   if (accept) state_nxt = TX_STAT;
            TX_STAT:   if (accept) state_nxt = TX_CHK;
            TX_CHK:    if (accept) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // A tick dropped on the very cycle TX_STAT is loaded is folded in, so it
    // rides in this frame's status rather than waiting for the next one.
    always_comb begin
        status_nxt               = '0;
        status_nxt[STAT_TIMEOUT] = timeout_q;
        status_nxt[STAT_OVERRUN] = overrun || ovr_tick;
        status_nxt[STAT_ALARM]   = alarm_bit;
    end

    // tx_data is loaded only on state entry so it stays frozen under
    // backpressure. In TX_STAT, tx_data is the status byte being sent.
    always_comb begin
        byte_nxt = tx_data;
        if (state_nxt != state) begin
            case (state_nxt)
                TX_HDR:  byte_nxt = FRAME_HDR;
                TX_SEQ:  byte_nxt = seq;
                TX_DATA: byte_nxt = sample;
                TX_STAT: byte_nxt = status_nxt;
                TX_CHK:  byte_nxt = FRAME_HDR ^ seq ^ sample ^ tx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meas_start <= 1'b0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b0;
            seq        <= '0;
            overrun    <= 1'b0;
            tcnt       <= '0;
            sample     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            meas_start <= (state_nxt == TRIGGER);
            tx_valid   <= is_tx(state_nxt);
            tx_data    <= byte_nxt;
            frame_done <= (state == TX_CHK) && accept;

            if ((state == TX_CHK) && accept) begin
                seq <= seq + 8'd1;
            end

            if (ovr_tick) begin
                overrun <= 1'b1;
            end else if ((state == TX_STAT) && accept && tx_data[STAT_OVERRUN]) begin
                overrun <= 1'b0;
            end

            if (state == TRIGGER) begin
                tcnt <= '0;
            end else if (state == WAIT_MEAS) begin
                tcnt <= tcnt + TW'(1);
            end

            if (state == WAIT_MEAS) begin
                if (meas_valid) begin
                    sample    <= meas_data;
                    timeout_q <= 1'b0;
                end else if (timeout_hit) begin
                    sample    <= '0;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temp_log_scheduler.sv
// Self-checking bench for temp_log_scheduler (PERIOD_CYCLES=100,
// TIMEOUT_CYCLES=20). Expected frame bytes are queued when each measurement
// is set up and compared as the UART side accepts them; a ready driver
// applies per-byte backpressure and checks tx_data stays frozen while held.
module tb_temp_log_scheduler;
    import temp_log_pkg::*;

    localparam int unsigned PERIOD  = 100;
    localparam int unsigned TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       meas_start;
    logic [7:0] meas_data;
    logic       meas_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       frame_done;
    logic [7:0] seq;
`ifdef TEMP_LOG_ALARM_EN
    logic [7:0] alarm_thresh;
    logic       alarm;
`endif

    always #5 clk = ~clk;

    temp_log_scheduler #(
        .PERIOD_CYCLES (PERIOD),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .meas_start  (meas_start),
        .meas_data   (meas_data),
        .meas_valid  (meas_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
`ifdef TEMP_LOG_ALARM_EN
        .alarm_thresh(alarm_thresh),
        .alarm       (alarm),
`endif
        .busy        (busy),
        .frame_done  (frame_done),
        .seq         (seq)
    );

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;
    logic [7:0]  exp_q[$];
    int unsigned stall_per_byte[FRAME_LEN];
    int unsigned byte_idx;
    int unsigned wait_cnt;
    logic [7:0]  model_seq;

    typedef struct {
        bit          do_meas;
        logic [7:0]  data;
        int unsigned delay;
        int unsigned stall;
        logic [7:0]  status;
    } vec_t;

    vec_t vecs[5];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Ready driver (just after each rising edge) and byte monitor (falling edge).
    initial begin : handshake
        logic       hold;
        logic [7:0] held;
        logic [7:0] exp_b;
        hold     = 1'b0;
        held     = '0;
        byte_idx = 0;
        wait_cnt = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tx_valid && (wait_cnt < stall_per_byte[byte_idx])) begin
                tx_ready = 1'b0;
                wait_cnt++;
            end else begin
                tx_ready = 1'b1;
            end
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                byte_idx = 0;
                wait_cnt = 0;
                hold     = 1'b0;
            end else begin
                if (hold) begin
                    check_eq("hold_valid", {31'd0, tx_valid}, 32'd1);
                    check_eq("hold_data", {24'd0, tx_data}, {24'd0, held});
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check_eq($sformatf("byte%0d_seq%0d", byte_idx, model_seq),
                                 {24'd0, tx_data}, {24'd0, exp_b});
                    end
                    byte_idx = (byte_idx + 1) % FRAME_LEN;
                    wait_cnt = 0;
                    hold     = 1'b0;
                end else begin
                    hold = tx_valid;
                    held = tx_data;
                end
            end
        end
    end

    task automatic wait_start(input string name);
        int unsigned n = 0;
        while (meas_start !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, "_start_seen"}, {31'd0, meas_start}, 32'd1);
    endtask

    // Called in the meas_start cycle; completes the frame and checks it.
    task automatic finish_frame(input bit do_meas, input logic [7:0] data,
                                input int unsigned delay, input logic [7:0] status,
                                input string name);
        logic [7:0]  smp;
        int unsigned n;
        smp = do_meas ? data : 8'h00;
        exp_q.push_back(FRAME_HDR);
        exp_q.push_back(model_seq);
        exp_q.push_back(smp);
        exp_q.push_back(status);
        exp_q.push_back(FRAME_HDR ^ model_seq ^ smp ^ status);
        @(posedge clk);
        #1;
        check_eq({name, "_start_pulse"}, {31'd0, meas_start}, 32'd0);
        check_eq({name, "_busy"}, {31'd0, busy}, 32'd1);
        if (do_meas) begin
            repeat (delay - 1) @(posedge clk);
            #1;
            meas_valid = 1'b1;
            meas_data  = data;
            @(posedge clk);
            #1;
            meas_valid = 1'b0;
            meas_data  = ~data;
            check_eq({name, "_hdr_latency"}, {31'd0, tx_valid}, 32'd1);
        end else begin
            repeat (TIMEOUT - 1) @(posedge clk);
            #1;
            check_eq({name, "_timeout_early"}, {31'd0, tx_valid}, 32'd0);
            @(posedge clk);
            #1;
            check_eq({name, "_timeout_edge"}, {31'd0, tx_valid}, 32'd1);
        end
        check_eq({name, "_hdr_byte"}, {24'd0, tx_data}, {24'd0, FRAME_HDR});
        n = 0;
        while (frame_done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, "_frame_done"}, {31'd0, frame_done}, 32'd1);
        model_seq = model_seq + 8'd1;
        check_eq({name, "_seq"}, {24'd0, seq}, {24'd0, model_seq});
        check_eq({name, "_bytes_left"}, exp_q.size(), 32'd0);
        check_eq({name, "_idle_valid"}, {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        check_eq({name, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
    endtask

    initial begin : watchdog
        #600_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned n;
        int unsigned starts;
        rst        = 1'b1;
        enable     = 1'b0;
        meas_valid = 1'b0;
        meas_data  = '0;
        model_seq  = '0;
        for (int i = 0; i < FRAME_LEN; i++) stall_per_byte[i] = 0;
`ifdef TEMP_LOG_ALARM_EN
        alarm_thresh = 8'hFF;
`endif
        vecs[0] = '{do_meas: 1'b1, data: 8'h37, delay: 5,  stall: 0, status: 8'h00};
        vecs[1] = '{do_meas: 1'b0, data: 8'h00, delay: 0,  stall: 0, status: 8'h01};
        vecs[2] = '{do_meas: 1'b1, data: 8'h5A, delay: 5,  stall: 7, status: 8'h00};
        vecs[3] = '{do_meas: 1'b1, data: 8'hC3, delay: 20, stall: 0, status: 8'h00};
        vecs[4] = '{do_meas: 1'b1, data: 8'hFF, delay: 1,  stall: 2, status: 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_meas_start", {31'd0, meas_start}, 32'd0);
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_eq("rst_seq", {24'd0, seq}, 32'd0);
        rst = 1'b0;

        starts = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (meas_start) starts++;
        end
        check_eq("disabled_no_start", starts, 32'd0);

        enable = 1'b1;
        n = 0;
        while (!meas_start && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("first_tick_latency", n, PERIOD);
        finish_frame(1'b1, 8'h12, 2, 8'h00, "first");

        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < FRAME_LEN; b++) stall_per_byte[b] = vecs[i].stall;
            wait_start($sformatf("vec%0d", i));
            finish_frame(vecs[i].do_meas, vecs[i].data, vecs[i].delay, vecs[i].status,
                         $sformatf("vec%0d", i));
        end
        for (int b = 0; b < FRAME_LEN; b++) stall_per_byte[b] = 0;

        // Header held off past a full period: the dropped tick shows in this
        // frame's status and is cleared for the next one.
        stall_per_byte[0] = 150;
        wait_start("overrun");
        finish_frame(1'b1, 8'h66, 4, 8'h02, "overrun");
        stall_per_byte[0] = 0;
        wait_start("post_overrun");
        finish_frame(1'b1, 8'h67, 4, 8'h00, "post_overrun");

`ifdef TEMP_LOG_ALARM_EN
        alarm_thresh = 8'h40;
        wait_start("alarm_hi");
        finish_frame(1'b1, 8'h41, 3, 8'h04, "alarm_hi");
        check_eq("alarm_hi_out", {31'd0, alarm}, 32'd1);
        wait_start("alarm_eq");
        finish_frame(1'b1, 8'h40, 3, 8'h00, "alarm_eq");
        check_eq("alarm_eq_out", {31'd0, alarm}, 32'd0);
        alarm_thresh = 8'hFF;
`endif

        for (int i = 0; i < 257; i++) begin
            wait_start("wrap");
            finish_frame(1'b1, 8'(i * 7 + 3), 3, 8'h00, "wrap");
        end

        // Reset while the sample byte is being held off.
        stall_per_byte[2] = 60;
        wait_start("rst_mid");
        exp_q.push_back(FRAME_HDR);
        exp_q.push_back(model_seq);
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        meas_valid = 1'b1;
        meas_data  = 8'h99;
        @(posedge clk);
        #1;
        meas_valid = 1'b0;
        n = 0;
        while (!(byte_idx == 2 && tx_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("rst_mid_reach_data", byte_idx, 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_seq", {24'd0, seq}, 32'd0);
        check_eq("rst_mid_tx_data", {24'd0, tx_data}, 32'd0);
        check_eq("rst_mid_meas_start", {31'd0, meas_start}, 32'd0);
        model_seq         = '0;
        stall_per_byte[2] = 0;
        wait_start("after_rst");
        finish_frame(1'b1, 8'h21, 4, 8'h00, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
